dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port between the processor and a debug/loader requester, such as a bench or a host-side memory initialiser.
- Sits between the processor's dmem outputs and the dmem syncram, inside the top-level wrapper.
- Processor has default priority.
- Debug requests are served in cycles when the processor is not accessing memory.
- If a debug request waits MAX_WAIT cycles, the processor is stalled for one cycle to serve it.

Parameters:
ADDR_W, 12, dmem address width
DATA_W, 32, dmem data width
MAX_WAIT, 8, cycles a pending debug request may wait before it forces a processor stall (must be >= 1)

Ports:
clock  input  1  master clock, rising edge; dmem is clocked on ~clock
reset  input  1  asynchronous, active-low reset
cpu_req  input  1  processor accesses dmem this cycle (load or store)
cpu_wren  input  1  processor write enable
cpu_address  input  ADDR_W  processor address
cpu_data  input  DATA_W  processor write data
cpu_q  output  DATA_W  read data to processor
cpu_stall  output  1  processor must hold PC and its request this cycle
dbg_valid  input  1  debug request pending
dbg_ready  output  1  debug request accepted this cycle
dbg_wren  input  1  debug request is a write
dbg_address  input  ADDR_W  debug address
dbg_data  input  DATA_W  debug write data
dbg_rdata  output  DATA_W  registered debug read data
dbg_rvalid  output  1  dbg_rdata valid, one-cycle pulse
mem_address  output  ADDR_W  to dmem
mem_data  output  DATA_W  to dmem
mem_wren  output  1  to dmem
mem_q  input  DATA_W  from dmem

Behaviour:
- States: IDLE, RD_RSP, WR_DONE. Reset state is IDLE.
- grant = dbg_valid & (state==IDLE) & (~cpu_req | starve) & reset_n. This is combinational.
- starve = (wait_cnt >= MAX_WAIT).
- dbg_ready = grant. The handshake completes in the same cycle; only one debug transaction is outstanding at a time.
- cpu_stall = cpu_req & grant. This is combinational.
- While stalled, the processor holds cpu_* stable. The same request is re-presented next cycle and is guaranteed service, because RD_RSP and WR_DONE block grants.
- Memory mux:
  - When grant=1, mem_* = dbg_*.
  - Otherwise mem_address = cpu_address, mem_data = cpu_data, mem_wren = cpu_wren & cpu_req.
- cpu_q = mem_q at all times, as a pass-through.
- State transitions, taken on the rising edge:
  - IDLE -> RD_RSP on grant & ~dbg_wren.
  - IDLE -> WR_DONE on grant & dbg_wren.
  - IDLE -> IDLE otherwise.
  - RD_RSP -> IDLE and WR_DONE -> IDLE unconditionally.
- Read latency is 1 cycle. On the edge that ends a read-grant cycle, dbg_rdata <= mem_q; this is valid because dmem latches on the falling edge.
- dbg_rvalid = (state==RD_RSP), high for exactly one cycle.
- dbg_rdata holds its value until the next debug read.
- wait_cnt (width clog2(MAX_WAIT+1)) updates on each rising edge:
  - cleared if ~dbg_valid or grant;
  - otherwise incremented, saturating at MAX_WAIT.
- After any debug grant, the following cycle belongs to the processor. Worst-case processor stall is 1 cycle per debug transaction.
- Simultaneous debug write and processor store to the same address: whichever is granted writes first; the stalled store lands next cycle, so the processor write wins.
- Reset asserted (reset=0), asynchronously:
  - state=IDLE, wait_cnt=0, dbg_rdata=0, dbg_rvalid=0;
  - dbg_ready=0, cpu_stall=0, mem_wren=0.
- Reset mid-operation: a pending RD_RSP is dropped and no dbg_rvalid pulse is issued. A debug requester must re-issue after reset.
- dbg_wren, dbg_address and dbg_data are ignored when dbg_valid=0.
- cpu_wren is ignored when cpu_req=0.

Test Plan:
1. Reset low, then release. Check all outputs 0 except the pass-throughs. Run cpu_req=1, wren=1, addr=5, data=0xA5 -> mem_wren=1, addr 5, no stall. A cpu read of 5 next cycle -> cpu_q=0xA5.
2. With cpu_req=0, dbg_valid=1, dbg_wren=0, addr=5 -> dbg_ready=1 that cycle. Next cycle dbg_rvalid=1 and dbg_rdata=0xA5. dbg_ready=0 in that RD_RSP cycle even with dbg_valid still high.
3. Hold cpu_req=1 continuously and dbg_valid=1 as a write (addr 7, 0x1234) -> dbg_ready=0 for 8 cycles. On cycle 9 dbg_ready=1 and cpu_stall=1. Cycle 10 cpu_stall=0. A cpu read of 7 later returns 0x1234.
4. Same-address collision: cpu store 0x11 and dbg write 0x22 to addr 3 under starvation. Debug is granted first, the cpu store follows next cycle, and a final read of 3 returns 0x11.
5. Assert reset during the RD_RSP cycle -> dbg_rvalid drops immediately with no pulse after release. wait_cnt restarts from 0, so starvation takes a full 8 cycles again.
6. Back-to-back debug writes with cpu_req=0 -> grants in alternating cycles only (grant, WR_DONE, grant, ...). cpu_stall stays 0 throughout.

Source files
------------

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Shares the dmem port between the processor (default priority)
//            and a debug/loader requester with a starvation-forced stall.
// Revision : 1.0
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wren,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_data,
  output logic [DATA_W-1:0] cpu_q,
  output logic              cpu_stall,
  input  logic              dbg_valid,
  output logic              dbg_ready,
  input  logic              dbg_wren,
  input  logic [ADDR_W-1:0] dbg_address,
  input  logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rvalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  localparam int                 c_cnt_w    = $clog2(MAX_WAIT + 1);
  localparam logic [c_cnt_w-1:0] c_max_wait = c_cnt_w'(MAX_WAIT);

  localparam logic [1:0] c_st_idle    = 2'd0;
  localparam logic [1:0] c_st_rd_rsp  = 2'd1;
  localparam logic [1:0] c_st_wr_done = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_cnt_w-1:0] r_wait_cnt;
  logic [DATA_W-1:0]  r_dbg_rdata;
  logic               w_starve;
  logic               w_grant;

  // Grant is gated by reset so nothing reaches dmem while reset is held.
  assign w_starve = (r_wait_cnt >= c_max_wait);
  assign w_grant  = dbg_valid & (r_state == c_st_idle) & (~cpu_req | w_starve) & reset;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = c_st_idle;
    case (r_state)
      c_st_idle: begin
        if (w_grant) begin
          w_state_nxt = dbg_wren ? c_st_wr_done : c_st_rd_rsp;
        end
      end
      c_st_rd_rsp:  w_state_nxt = c_st_idle;
      c_st_wr_done: w_state_nxt = c_st_idle;
      default:      w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    dbg_ready  = w_grant;
    cpu_stall  = cpu_req & w_grant;
    dbg_rvalid = (r_state == c_st_rd_rsp);
    cpu_q      = mem_q;
    if (w_grant) begin
      mem_address = dbg_address;
      mem_data    = dbg_data;
      mem_wren    = dbg_wren;
    end else begin
      mem_address = cpu_address;
      mem_data    = cpu_data;
      mem_wren    = cpu_wren & cpu_req & reset;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wait_cnt <= '0;
    end else if (!dbg_valid || w_grant) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != c_max_wait) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // dmem latches on the falling edge, so mem_q already holds the read data here.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_dbg_rdata <= '0;
    end else if (w_grant && !dbg_wren) begin
      r_dbg_rdata <= mem_q;
    end
  end

  assign dbg_rdata = r_dbg_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Directed and randomized bench for dmem_arbiter with a falling-edge
//            dmem model and a cycle-level reference of the arbitration rules.
// Revision : 1.0
// ============================================================================
module tb_dmem_arbiter;

  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 8;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              cpu_req = 1'b0, cpu_wren = 1'b0;
  logic [ADDR_W-1:0] cpu_address = '0;
  logic [DATA_W-1:0] cpu_data = '0;
  logic [DATA_W-1:0] cpu_q;
  logic              cpu_stall;
  logic              dbg_valid = 1'b0, dbg_wren = 1'b0;
  logic              dbg_ready;
  logic [ADDR_W-1:0] dbg_address = '0;
  logic [DATA_W-1:0] dbg_data = '0;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_rvalid;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q = '0;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) u_dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_wren(cpu_wren), .cpu_address(cpu_address),
    .cpu_data(cpu_data), .cpu_q(cpu_q), .cpu_stall(cpu_stall),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_wren(dbg_wren),
    .dbg_address(dbg_address), .dbg_data(dbg_data),
    .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_q(mem_q)
  );

  always #5 clock = ~clock;

  // dmem syncram: clocked on the falling edge, old data on read-during-write
  logic [DATA_W-1:0] ram [0:4095] = '{default: '0};
  always @(negedge clock) begin
    if (mem_wren) ram[mem_address] <= mem_data;
    mem_q <= ram[mem_address];
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state: plain integers describing who owns the port and for how long
  logic [DATA_W-1:0] ref_mem [0:4095] = '{default: '0};
  int          m_age      = 0;
  bit          m_busy     = 0;
  bit          m_rvalid   = 0;
  logic [31:0] m_rdata    = '0;
  bit          last_grant = 0;
  bit          last_stall = 0;
  logic        obs_ready  = 1'b0;
  logic        obs_stall  = 1'b0;

  task automatic model_reset();
    m_age = 0; m_busy = 0; m_rvalid = 0; m_rdata = '0;
    last_grant = 0; last_stall = 0;
  endtask

  task automatic step(input logic creq, input logic cwr, input logic [11:0] ca,
                      input logic [31:0] cd, input logic dv, input logic dwr,
                      input logic [11:0] da, input logic [31:0] dd);
    bit          g;
    logic [11:0] e_addr;
    logic [31:0] e_data, e_q;
    logic        e_wren;
    @(posedge clock);
    #1;
    cpu_req = creq; cpu_wren = cwr; cpu_address = ca; cpu_data = cd;
    dbg_valid = dv; dbg_wren = dwr; dbg_address = da; dbg_data = dd;
    #2;
    g      = dv && !m_busy && (!creq || (m_age >= MAX_WAIT));
    e_addr = g ? da : ca;
    e_data = g ? dd : cd;
    e_wren = g ? dwr : (creq && cwr);
    check("dbg_ready", dbg_ready, g);
    check("cpu_stall", cpu_stall, creq && g);
    check("mem_address", mem_address, e_addr);
    check("mem_data", mem_data, e_data);
    check("mem_wren", mem_wren, e_wren);
    check("dbg_rvalid", dbg_rvalid, m_rvalid);
    check("dbg_rdata", dbg_rdata, m_rdata);
    obs_ready = dbg_ready;
    obs_stall = cpu_stall;
    e_q = ref_mem[e_addr];
    if (e_wren) ref_mem[e_addr] = e_data;
    @(negedge clock);
    #2;
    check("cpu_q", cpu_q, e_q);
    m_rvalid = g && !dwr;
    if (g && !dwr) m_rdata = e_q;
    m_busy = g;
    if (!dv || g) m_age = 0;
    else if (m_age < MAX_WAIT) m_age++;
    last_grant = g;
    last_stall = creq && g;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    bit          got;
    bit          busy_mode;
    logic        c_req, c_wr, d_v, d_wr;
    logic [11:0] c_a, d_a;
    logic [31:0] c_d, d_d;

    // Reset held with live requests: nothing may reach dmem or the requester
    cpu_req = 1; cpu_wren = 1; cpu_address = 12'd5; dbg_valid = 1;
    #3;
    check("rst_dbg_ready", dbg_ready, 0);
    check("rst_cpu_stall", cpu_stall, 0);
    check("rst_mem_wren", mem_wren, 0);
    check("rst_dbg_rvalid", dbg_rvalid, 0);
    check("rst_dbg_rdata", dbg_rdata, 0);
    cpu_req = 0; cpu_wren = 0; dbg_valid = 0;
    @(posedge clock); @(posedge clock); #1;
    reset = 1;

    // Test 1: cpu store then read back
    step(1, 1, 12'd5, 32'hA5, 0, 0, 12'd0, 0);
    step(1, 0, 12'd5, 0, 0, 0, 12'd0, 0);
    check("t1_cpu_q", cpu_q, 32'hA5);

    // Test 2: debug read while cpu idle; RD_RSP blocks a second grant
    step(0, 0, 12'd0, 0, 1, 0, 12'd5, 0);
    check("t2_ready", obs_ready, 1);
    step(0, 0, 12'd0, 0, 1, 0, 12'd5, 0);
    check("t2_ready_rsp", obs_ready, 0);
    check("t2_rvalid", dbg_rvalid, 1);
    check("t2_rdata", dbg_rdata, 32'hA5);
    step(0, 0, 12'd0, 0, 0, 0, 12'd0, 0);

    // Test 3: starvation forces a one-cycle stall on cycle MAX_WAIT+1
    n = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(1, 0, 12'd0, 0, 1, 1, 12'd7, 32'h1234);
      n++;
      if (obs_ready) got = 1;
    end
    check("t3_starve_cycles", n, MAX_WAIT + 1);
    check("t3_stall", obs_stall, 1);
    step(1, 0, 12'd0, 0, 0, 0, 12'd0, 0);
    check("t3_no_stall_after", obs_stall, 0);
    step(1, 0, 12'd7, 0, 0, 0, 12'd0, 0);
    check("t3_cpu_q", cpu_q, 32'h1234);

    // Test 4: same-address collision, stalled cpu store lands last
    n = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(1, 1, 12'd3, 32'h11, 1, 1, 12'd3, 32'h22);
      n++;
      if (obs_ready) got = 1;
    end
    check("t4_starve_cycles", n, MAX_WAIT + 1);
    step(1, 1, 12'd3, 32'h11, 0, 0, 12'd0, 0);
    check("t4_store_no_stall", obs_stall, 0);
    step(1, 0, 12'd3, 0, 0, 0, 12'd0, 0);
    check("t4_cpu_q", cpu_q, 32'h11);

    // Test 5: reset during RD_RSP drops the response and the wait count
    step(0, 0, 12'd0, 0, 1, 0, 12'd5, 0);
    check("t5_ready", obs_ready, 1);
    @(posedge clock); #1;
    cpu_req = 1; cpu_wren = 1; dbg_valid = 1; dbg_wren = 0;
    #1;
    check("t5_rvalid_before", dbg_rvalid, 1);
    reset = 0;
    #1;
    check("t5_rvalid_reset", dbg_rvalid, 0);
    check("t5_ready_reset", dbg_ready, 0);
    check("t5_mem_wren_reset", mem_wren, 0);
    cpu_req = 0; cpu_wren = 0; dbg_valid = 0;
    model_reset();
    @(posedge clock); @(posedge clock); #1;
    reset = 1;
    #1;
    check("t5_rvalid_after", dbg_rvalid, 0);
    check("t5_rdata_after", dbg_rdata, 0);
    n = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(1, 0, 12'd1, 0, 1, 1, 12'd9, 32'h55);
      n++;
      if (obs_ready) got = 1;
    end
    check("t5_starve_cycles", n, MAX_WAIT + 1);
    step(0, 0, 12'd0, 0, 0, 0, 12'd0, 0);

    // Test 6: back-to-back debug writes grant only every other cycle
    n = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 12'd0, 0, 1, 1, 12'(8 + n), 32'(100 + n));
      check("t6_ready", obs_ready, (i % 2) == 0);
      check("t6_stall", obs_stall, 0);
      if (obs_ready) n++;
    end
    step(1, 0, 12'd9, 0, 0, 0, 12'd0, 0);
    check("t6_cpu_q", cpu_q, 32'd101);

    // Randomized traffic: cpu holds while stalled, debug holds until accepted
    c_req = 0; c_wr = 0; c_a = '0; c_d = '0;
    d_v = 0; d_wr = 0; d_a = '0; d_d = '0;
    busy_mode = 0;
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) busy_mode = ($urandom_range(0, 1) == 1);
      if (!last_stall) begin
        c_req = busy_mode ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 9) < 5);
        c_wr  = $urandom_range(0, 1) == 1;
        c_a   = 12'($urandom_range(0, 15));
        c_d   = $urandom;
      end
      if (!d_v || last_grant) begin
        d_v  = $urandom_range(0, 9) < 4;
        d_wr = $urandom_range(0, 1) == 1;
        d_a  = 12'($urandom_range(0, 15));
        d_d  = $urandom;
      end
      step(c_req, c_wr, c_a, c_d, d_v, d_wr, d_a, d_d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
